conv_encoder: RTL and testbench
===============================

# conv_encoder

Rate-1/2, constraint-length-3 (4-state) convolutional encoder producing the 16-bit codewords that `PipeViterbi` consumes on `data_recv`. It accepts one 8-bit data word per valid/ready handshake and encodes it serially, one bit per cycle, MSB first. It presents the 16-bit codeword on a valid/ready output port. It sits on the transmit side of the link (or in the testbench loopback) directly ahead of the channel model and decoder.

## Interface
- `G0`, default 3'b111: generator for the upper bit of each symbol; bit 2 taps the current bit, bit 1 taps d(t-1), bit 0 taps d(t-2).
- `G1`, default 3'b101: generator for the lower bit of each symbol, same tap order.
- `clk`  in  1  Single clock; all state changes on the rising edge.
- `rst`  in  1  Reset, asynchronous and active-low.
- `data_in`  in  8  Data word to encode; bit 7 is encoded first.
- `in_valid`  in  1  `data_in` is valid.
- `in_ready`  out  1  Encoder can accept a word this cycle.
- `data_enc`  out  16  Codeword; symbol k (k=1..8) is at bits [17-2k:16-2k], as {G0 bit, G1 bit}.
- `out_valid`  out  1  `data_enc` holds a complete codeword.
- `out_ready`  in  1  Downstream accepts the codeword this cycle.

## Operation
- Trellis state register `s[1:0] = {d(t-1), d(t-2)}`.
- For input bit d: c0 = ^(G0 & {d,s}) and c1 = ^(G1 & {d,s}). Next state is {d, s[1]}.
- FSM states:
  - IDLE: `in_ready`=1, `out_valid`=0. On `in_valid & in_ready`, latch `data_in` into the shift register, clear bit counter `cnt[2:0]`, and go to ENC.
  - ENC: each cycle, encode the MSB of the shift register, shift the data left by 1, shift {c0,c1} into the LSBs of the codeword register, and increment `cnt`. When `cnt`==7 (8th bit), go to OUT. `in_ready`=0.
  - OUT: `out_valid`=1 and `data_enc` is held stable. If `out_ready`=0, stay in OUT.
    - If `out_ready`=1 and `in_valid`=0, go to IDLE.
    - If `out_ready`=1 and `in_valid`=1, the codeword is consumed and the new word is accepted in the same cycle, and the FSM goes directly to ENC.
- `in_ready` is combinational: (state==IDLE) | (state==OUT & `out_ready`), forced 0 while `rst` is low.
- `data_in` is ignored unless a handshake occurs. `out_ready` is ignored outside OUT.
- The trellis state persists across words unless the macro below is defined.
- Reset values (asynchronous):
  - FSM=IDLE, `s`=2'b00, `cnt`=0.
  - `data_enc`=16'h0000, `out_valid`=0.
- Reset asserted mid-ENC or mid-OUT aborts the word. No partial codeword is ever presented.

## Timing
- Word accepted at edge E0. Bits are encoded on edges E1..E8. `out_valid` rises after E8.
- Latency: 8 cycles from accept to `out_valid`.
- Throughput: one word per 9 cycles when back-to-back via the OUT-to-ENC path. It is 10 cycles if the FSM passes through IDLE.
- Backpressure: OUT is held indefinitely. `data_enc` and `out_valid` must not change until `out_ready`=1.
- `data_enc` is updated only during ENC. The ENC shift order guarantees symbol 1 ends in bits [15:14].

## Configuration
- `CONV_ENC_WORD_RESET_EN` defined:
  - `s` is cleared to 2'b00 on every input handshake.
  - Each codeword is encoded from the zero state, matching a decoder that restarts its trellis per word.
- Not defined:
  - `s` is cleared only by `rst`.
  - Words form one continuous code stream.

## Test plan
- After reset, send 8'h80 -> 8 cycles later `out_valid`=1 and `data_enc`=16'hEC00; `s`=2'b00.
- From reset, send 8'hFF -> `data_enc`=16'hDAAA. Then send 8'h00 -> 16'h7000 without the macro, 16'h0000 with `CONV_ENC_WORD_RESET_EN`.
- Hold `out_ready`=0 for 20 cycles in OUT -> `data_enc` and `out_valid` remain constant and `in_ready`=0. Raising `out_ready` with `in_valid`=1 accepts the next word in the same cycle, and the next `out_valid` follows 8 cycles later.
- Stream 4 words with `in_valid` and `out_ready` tied high -> one codeword every 9 cycles. Codewords match the reference model (including carried state per macro setting).
- Assert `rst` low during ENC cycle 4 -> `out_valid`, `data_enc` and `s` clear immediately. After release, 8'h80 again yields 16'hEC00.
- Loopback: 64 random words through `conv_encoder` into `PipeViterbi` with no errors -> decoded bytes equal the inputs.

Source files
------------

// File: rtl/conv_encoder.sv
// Rate-1/2, K=3 convolutional encoder. It takes one 8-bit word per handshake,
// encodes it MSB first at one bit per cycle, and presents a 16-bit codeword.
// Optional build macro: CONV_ENC_WORD_RESET_EN. When it is defined, the trellis
// state is cleared on every accepted word. When it is undefined, the words form
// one continuous code stream.
module conv_encoder #(
    parameter logic [2:0] G0 = 3'b111,
    parameter logic [2:0] G1 = 3'b101
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  data_in,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [15:0] data_enc,
    output logic        out_valid,
    input  logic        out_ready
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ENC  = 2'd1;
    localparam logic [1:0] OUT  = 2'd2;

    logic [1:0]  state;
    logic [7:0]  sreg;
    logic [1:0]  s;
    logic [2:0]  cnt;
    logic [15:0] enc;
    logic        d;
    logic        c0;
    logic        c1;
    logic        accept;

    // Symbol for the current MSB, and the handshake qualifier
    always_comb begin
        d        = sreg[7];
        c0       = ^(G0 & {d, s});
        c1       = ^(G1 & {d, s});
        in_ready = rst & ((state == IDLE) | ((state == OUT) & out_ready));
        accept   = in_valid & in_ready;
    end

    assign data_enc  = enc;
    assign out_valid = (state == OUT);

    // Controller, serial encoder and codeword shift register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            sreg  <= '0;
            s     <= '0;
            cnt   <= '0;
            enc   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept)
                        state <= ENC;
                end
                ENC: begin
                    enc  <= {enc[13:0], c0, c1};
                    sreg <= {sreg[6:0], 1'b0};
                    s    <= {d, s[1]};
                    cnt  <= cnt + 3'd1;
                    if (cnt == 3'd7)
                        state <= OUT;
                end
                OUT: begin
                    if (out_ready)
                        state <= in_valid ? ENC : IDLE;
                end
                default: state <= IDLE;
            endcase
            // The load is shared by IDLE and by the OUT-to-ENC path.
            // in_ready is low in ENC, so it cannot collide with the shift.
            if (accept) begin
                sreg <= data_in;
                cnt  <= '0;
`ifdef CONV_ENC_WORD_RESET_EN
                s    <= '0;
`endif
            end
        end
    end

endmodule

// File: tb/tb_conv_encoder.sv
// Scoreboard bench for conv_encoder, using a bit-history reference model.
module tb_conv_encoder;

    localparam logic [2:0] G0 = 3'b111;
    localparam logic [2:0] G1 = 3'b101;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  data_in = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] data_enc;
    logic        out_valid;
    logic        out_ready = 1'b0;

    conv_encoder #(.G0(G0), .G1(G1)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .in_valid(in_valid),
        .in_ready(in_ready), .data_enc(data_enc), .out_valid(out_valid),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Reference model: the whole transmitted bit stream, padded with two leading zeros
    bit hist[$];

    function automatic void model_clear();
        hist.delete();
        hist.push_back(1'b0);
        hist.push_back(1'b0);
    endfunction

    function automatic logic [15:0] model_word(input logic [7:0] w);
        logic [15:0] cw;
        int n;
        bit b, b1, b2;
        cw = '0;
`ifdef CONV_ENC_WORD_RESET_EN
        model_clear();
`endif
        for (int i = 7; i >= 0; i--) begin
            b  = w[i];
            n  = hist.size();
            b1 = hist[n-1];
            b2 = hist[n-2];
            hist.push_back(b);
            cw[2*i+1] = (G0[2] & b) ^ (G0[1] & b1) ^ (G0[0] & b2);
            cw[2*i]   = (G1[2] & b) ^ (G1[1] & b1) ^ (G1[0] & b2);
        end
        return cw;
    endfunction

    logic [15:0] exp_q[$];
    int unsigned acc_q[$];

    // Stimulus side of the scoreboard: record the expected codeword at each handshake
    always @(negedge clk) begin
        if (rst && in_valid && in_ready) begin
            exp_q.push_back(model_word(data_in));
            acc_q.push_back(cyc + 1);
        end
    end

    bit          fresh = 1'b1;
    logic [15:0] held;
    logic [15:0] last_cw = '0;
    int unsigned last_pres = 0;
    bit          have_pres = 1'b0;
    bit          check_tp = 1'b0;
    bit          rand_bp = 1'b0;

    // Monitor side: latency, hold stability, backpressure and codeword comparison
    always @(negedge clk) begin
        if (rst && out_valid) begin
            if (fresh) begin
                fresh = 1'b0;
                held  = data_enc;
                if (acc_q.size() == 0)
                    fail_now("unexpected_out_valid");
                else
                    check("latency", cyc - acc_q.pop_front(), 8);
                if (check_tp && have_pres)
                    check("throughput", cyc - last_pres, 9);
                last_pres = cyc;
                have_pres = 1'b1;
            end else begin
                check("hold_stable", {16'h0, data_enc}, {16'h0, held});
            end
            if (!out_ready)
                check("in_ready_backpressure", {31'h0, in_ready}, 0);
            if (out_ready) begin
                if (exp_q.size() == 0)
                    fail_now("codeword_no_expectation");
                else
                    check("codeword", {16'h0, data_enc}, {16'h0, exp_q.pop_front()});
                last_cw = data_enc;
                fresh   = 1'b1;
            end
        end
    end

    task automatic flush_model();
        exp_q.delete();
        acc_q.delete();
        model_clear();
        fresh = 1'b1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        flush_model();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic send(input logic [7:0] w);
        int n;
        bit ok;
        n  = 0;
        ok = 1'b0;
        data_in  = w;
        in_valid = 1'b1;
        while (n < 200) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
            if (rand_bp) out_ready = 1'($urandom_range(0, 1));
            n++;
        end
        if (!ok) fail_now("send_timeout");
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 200) begin
            @(posedge clk);
            #1;
            if (rand_bp) out_ready = 1'($urandom_range(0, 1));
            n++;
        end
        if (n >= 200) fail_now("drain_timeout");
        out_ready = 1'b1;
    endtask

    initial begin
        int n;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", {31'h0, out_valid}, 0);
        check("rst_data_enc", {16'h0, data_enc}, 0);
        check("rst_in_ready", {31'h0, in_ready}, 0);
        check("rst_s", {30'h0, dut.s}, 0);
        check("rst_cnt", {29'h0, dut.cnt}, 0);
        rst = 1'b1;
        #1;
        check("idle_in_ready", {31'h0, in_ready}, 1);

        // Single impulse word from the zero state
        out_ready = 1'b1;
        send(8'h80);
        wait_idle();
        check("cw_80", {16'h0, last_cw}, 32'hEC00);
        check("s_after_80", {30'h0, dut.s}, 0);

        // All-ones word, then a zero word that depends on the carried state
        do_reset();
        send(8'hFF);
        wait_idle();
        check("cw_FF", {16'h0, last_cw}, 32'hDAAA);
        send(8'h00);
        wait_idle();
`ifdef CONV_ENC_WORD_RESET_EN
        check("cw_00_after_FF", {16'h0, last_cw}, 32'h0000);
`else
        check("cw_00_after_FF", {16'h0, last_cw}, 32'h7000);
`endif

        // Long backpressure hold, then consume and accept in the same cycle
        out_ready = 1'b0;
        send(8'h3C);
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            if (out_valid) break;
            n++;
        end
        if (n >= 20) fail_now("bp_out_valid_timeout");
        repeat (20) @(posedge clk);
        #1;
        data_in   = 8'($urandom);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        check("bp_accept_in_ready", {31'h0, in_ready}, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_idle();

        // Four back-to-back words via the OUT-to-ENC path
        check_tp  = 1'b1;
        have_pres = 1'b0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            data_in = 8'($urandom);
            n = 0;
            while (n < 30) begin
                @(negedge clk);
                if (in_ready) break;
                n++;
            end
            if (n >= 30) fail_now("stream_timeout");
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        wait_idle();
        check_tp = 1'b0;

        // Random words with random backpressure
        rand_bp = 1'b1;
        for (int k = 0; k < 24; k++) begin
            send(8'($urandom));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        wait_idle();
        rand_bp   = 1'b0;
        out_ready = 1'b1;

        // Reset during the fourth encode cycle aborts the word
        send(8'hA5);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        flush_model();
        #1;
        check("abort_out_valid", {31'h0, out_valid}, 0);
        check("abort_data_enc", {16'h0, data_enc}, 0);
        check("abort_s", {30'h0, dut.s}, 0);
        check("abort_in_ready", {31'h0, in_ready}, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        send(8'h80);
        wait_idle();
        check("cw_80_after_abort", {16'h0, last_cw}, 32'hEC00);

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
